// File: rtl/cas_adc_pkg.sv
// Shared definitions for the cassette ADC slicer: sample width and the
// controller state encoding.
package cas_adc_pkg;

   localparam int ADC_W = 12;

   typedef enum logic [1:0] {
      CLEAR,
      IDLE,
      READ,
      UPDATE
   } state_t;

endpackage

// File: rtl/cas_adc_ring.sv
// Simple dual-port sample ring: one write port, one registered read port,
// shaped so synthesis maps it onto a block RAM.
module cas_adc_ring #(
   parameter int ADDR_W = 9,
   parameter int DATA_W = 12
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [0:(1 << ADDR_W) - 1];

   // NOTE: the array has no reset branch; a reset would block RAM inference,
   // so the controller zeroes it with an explicit sweep instead.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      rdata <= mem[raddr];
   end

endmodule

// File: rtl/cas_adc_slicer.sv
// Cassette input slicer: keeps a running average of the last 2^DEPTH_LOG2
// ADC samples and slices each new sample against it with hysteresis.
module cas_adc_slicer
   import cas_adc_pkg::*;
#(
   parameter int DEPTH_LOG2 = 9,
   parameter int HYST       = 100,
   parameter int INVERT     = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [ADC_W-1:0] adc_data,
   input  logic             adc_sync,
   output logic             cass_bit,
   output logic [ADC_W-1:0] level,
   output logic [ADC_W-1:0] avg,
   output logic             sample_stb,
   output logic             ready,
   output logic             overrun
);

   localparam int TOT_W = ADC_W + DEPTH_LOG2;
   localparam logic [DEPTH_LOG2-1:0] WPTR_LAST = '1;
   localparam logic [DEPTH_LOG2-1:0] WPTR_ONE  = DEPTH_LOG2'(1);
   localparam logic signed [ADC_W+1:0] HYST_S  = (ADC_W + 2)'(HYST);

   state_t                state, state_next;
   logic                  sync_q;
   logic                  toggle;
   logic [DEPTH_LOG2-1:0] wptr;
   logic [TOT_W-1:0]      total, total_new;
   logic [ADC_W-1:0]      avg_new;
   logic [ADC_W-1:0]      cur_sample, pend_data, old_sample, ring_wdata;
   logic                  pend_valid;
   logic                  ring_we;
   logic signed [ADC_W+1:0] new_s, avg_s, lo_th, hi_th;
   logic                  cass_next;

   assign toggle = (adc_sync != sync_q);
   assign ready  = (state != CLEAR);

   // The write pointer doubles as the address counter of the clearing sweep.
   assign ring_we    = (state == CLEAR) || (state == UPDATE);
   assign ring_wdata = (state == UPDATE) ? cur_sample : '0;

   cas_adc_ring #(
      .ADDR_W (DEPTH_LOG2),
      .DATA_W (ADC_W)
   ) u_ring (
      .clk   (clk),
      .we    (ring_we),
      .waddr (wptr),
      .wdata (ring_wdata),
      .raddr (wptr),
      .rdata (old_sample)
   );

   // NOTE: sequential state is written with <= so every register samples the
   // pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (reset) state <= CLEAR;
      else       state <= state_next;
   end

   // NOTE: state_next gets its default before the case, so no path leaves it
   // unassigned and no latch is inferred.
   always_comb begin
      state_next = state;
      unique case (state)
         CLEAR:   if (wptr == WPTR_LAST) state_next = IDLE;
         IDLE:    if (pend_valid || toggle) state_next = READ;
         READ:    state_next = UPDATE;
         UPDATE:  state_next = IDLE;
         default: state_next = CLEAR;
      endcase
   end

   // Accumulator and slicer; comparisons are signed and two bits wider than
   // a sample so thresholds below zero or above full scale cannot wrap.
   always_comb begin
      total_new = total - {{DEPTH_LOG2{1'b0}}, old_sample}
                        + {{DEPTH_LOG2{1'b0}}, cur_sample};
      avg_new   = total_new[TOT_W-1:DEPTH_LOG2];
      new_s     = $signed({2'b00, cur_sample});
      avg_s     = $signed({2'b00, avg_new});
      lo_th     = avg_s - HYST_S;
      hi_th     = avg_s + HYST_S;
      cass_next = cass_bit;
      if (new_s < lo_th)      cass_next = (INVERT != 0);
      else if (new_s > hi_th) cass_next = (INVERT == 0);
   end

   always_ff @(posedge clk) begin
      sync_q <= adc_sync;
      if (reset) begin
         cass_bit   <= 1'b0;
         level      <= '0;
         avg        <= '0;
         sample_stb <= 1'b0;
         overrun    <= 1'b0;
         total      <= '0;
         wptr       <= '0;
         cur_sample <= '0;
         pend_data  <= '0;
         pend_valid <= 1'b0;
      end else begin
         sample_stb <= (state == UPDATE);
         unique case (state)
            CLEAR: wptr <= wptr + WPTR_ONE;
            IDLE: begin
               // A waiting sample is older, so it goes first.
               if (pend_valid) begin
                  cur_sample <= pend_data;
                  pend_valid <= toggle;
                  if (toggle) pend_data <= adc_data;
               end else if (toggle) begin
                  cur_sample <= adc_data;
               end
            end
            READ, UPDATE: begin
               if (toggle) begin
                  pend_data  <= adc_data;
                  pend_valid <= 1'b1;
                  if (pend_valid) overrun <= 1'b1;
               end
               if (state == UPDATE) begin
                  wptr     <= wptr + WPTR_ONE;
                  total    <= total_new;
                  avg      <= avg_new;
                  level    <= cur_sample;
                  cass_bit <= cass_next;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_cas_adc_slicer.sv
// Directed bench for cas_adc_slicer: clearing sweep, window fill, slicer
// thresholds from a vector table, and the overlap and reset corner cases.
module tb_cas_adc_slicer;

   logic        clk = 1'b0;
   logic        reset;
   logic [11:0] adc_data;
   logic        adc_sync;
   logic        cass_bit;
   logic [11:0] level;
   logic [11:0] avg;
   logic        sample_stb;
   logic        ready;
   logic        overrun;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [11:0] value;
      logic        exp_cass;
      logic [11:0] exp_avg;
   } vec_t;

   vec_t vecs [9];

   always #5 clk = ~clk;

   cas_adc_slicer dut (
      .clk        (clk),
      .reset      (reset),
      .adc_data   (adc_data),
      .adc_sync   (adc_sync),
      .cass_bit   (cass_bit),
      .level      (level),
      .avg        (avg),
      .sample_stb (sample_stb),
      .ready      (ready),
      .overrun    (overrun)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   // Issue one sample at the current negedge and wait for its strobe; lat is
   // the number of negedges until sample_stb, or 0 on timeout.
   task automatic send(input logic [11:0] v, output int lat);
      adc_data = v;
      adc_sync = ~adc_sync;
      lat = 0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (sample_stb) begin
            lat = k;
            break;
         end
      end
   endtask

   // Called at the negedge where reset was released.
   task automatic clear_sweep(input string tag, input bit poke);
      int outs_seen = 0;
      for (int i = 1; i <= 600; i++) begin
         if (poke && (i == 5 || i == 6 || i == 300)) adc_sync = ~adc_sync;
         @(negedge clk);
         if (i == 511) check({tag, " ready_at_511"}, ready, 0);
         if (i == 512) check({tag, " ready_at_512"}, ready, 1);
         if (cass_bit || level != 0 || avg != 0 || sample_stb || overrun) outs_seen++;
      end
      check({tag, " outputs_zero"}, outs_seen, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int lat;
      int bad_lat;
      int bad_cass;
      int stb_n;
      int t1;
      logic [11:0] lv0, lv1;

      // Window at 2048; each entry replaces one 2048 slot.
      vecs[0] = '{12'd1500, 1'b1, 12'd2046};
      vecs[1] = '{12'd2600, 1'b0, 12'd2048};
      vecs[2] = '{12'd1500, 1'b1, 12'd2046};
      vecs[3] = '{12'd2600, 1'b0, 12'd2048};
      vecs[4] = '{12'd2000, 1'b0, 12'd2047};
      vecs[5] = '{12'd1946, 1'b1, 12'd2047};
      vecs[6] = '{12'd2147, 1'b1, 12'd2047};
      vecs[7] = '{12'd2149, 1'b0, 12'd2048};
      vecs[8] = '{12'd1947, 1'b0, 12'd2047};

      reset    = 1'b1;
      adc_data = '0;
      adc_sync = 1'b0;

      // Reset state and clearing sweep.
      repeat (3) @(negedge clk);
      check("rst cass_bit", cass_bit, 0);
      check("rst level", level, 0);
      check("rst avg", avg, 0);
      check("rst sample_stb", sample_stb, 0);
      check("rst ready", ready, 0);
      check("rst overrun", overrun, 0);
      reset = 1'b0;
      clear_sweep("init", 1'b0);

      // Zero samples: avg 0, no false trigger.
      bad_lat = 0;
      bad_cass = 0;
      for (int i = 0; i < 10; i++) begin
         send(12'd0, lat);
         if (i == 0) check("zero first_latency", lat, 3);
         if (lat != 3) bad_lat++;
         if (cass_bit) bad_cass++;
         repeat (40 - lat) @(negedge clk);
      end
      check("zero latency_all", bad_lat, 0);
      check("zero cass_bit", bad_cass, 0);
      check("zero avg", avg, 0);
      check("zero level", level, 0);

      // Fill the window with 2048.
      bad_lat = 0;
      bad_cass = 0;
      for (int i = 1; i <= 512; i++) begin
         send(12'd2048, lat);
         if (lat != 3) bad_lat++;
         if (cass_bit) bad_cass++;
         if (i == 511) check("fill avg_at_511", avg, 2044);
         if (i == 512) check("fill avg_at_512", avg, 2048);
         repeat (40 - lat) @(negedge clk);
      end
      check("fill latency_all", bad_lat, 0);
      check("fill cass_bit", bad_cass, 0);
      check("fill overrun", overrun, 0);

      // Slicer vectors around the hysteresis band.
      foreach (vecs[i]) begin
         send(vecs[i].value, lat);
         check($sformatf("vec%0d latency", i), lat, 3);
         check($sformatf("vec%0d cass_bit", i), cass_bit, vecs[i].exp_cass);
         check($sformatf("vec%0d avg", i), avg, vecs[i].exp_avg);
         check($sformatf("vec%0d level", i), level, vecs[i].value);
         repeat (10) @(negedge clk);
      end

      // Toggles on three consecutive cycles: middle sample is lost.
      adc_data = 12'd111;
      adc_sync = ~adc_sync;
      @(negedge clk);
      adc_data = 12'd222;
      adc_sync = ~adc_sync;
      @(negedge clk);
      adc_data = 12'd333;
      adc_sync = ~adc_sync;
      stb_n = 0;
      t1 = 0;
      lv0 = '0;
      lv1 = '0;
      for (int k = 3; k <= 20; k++) begin
         @(negedge clk);
         if (sample_stb) begin
            if (stb_n == 0) lv0 = level;
            else if (stb_n == 1) begin
               lv1 = level;
               t1 = k;
            end
            stb_n++;
         end
      end
      check("burst stb_count", stb_n, 2);
      check("burst first_level", lv0, 111);
      check("burst second_level", lv1, 333);
      check("burst second_time", t1, 6);
      check("burst overrun", overrun, 1);

      // Reset two cycles after a toggle aborts the update.
      adc_data = 12'd700;
      adc_sync = ~adc_sync;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("abort sample_stb", sample_stb, 0);
      check("abort overrun", overrun, 0);
      check("abort ready", ready, 0);
      check("abort level", level, 0);
      reset = 1'b0;
      clear_sweep("abort", 1'b1);
      stb_n = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (sample_stb) stb_n++;
      end
      check("abort no_pending", stb_n, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
